ps2_host_tx: RTL and testbench

// Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xFF reset, 0xED set-LEDs) to the keyboard.
// It shares the open-drain ps2_clk_io/ps2_data_io pins with the existing scancode receiver.

---
 rtl/ps2_host_tx.sv | 226 ++++++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// ----------------------------------------------------------------------------
// ps2_host_tx
// Host-to-device PS/2 transmitter. Sends one command byte (e.g. 0xFF reset,
// 0xED set-LEDs) to the keyboard over the open-drain clock/data pins shared
// with the scancode receiver.
//
// Frame sequence:
//   - Inhibit: hold the clock low.
//   - Request-to-send: release the clock with data held low (start bit).
//   - On each device clock fall, drive the next bit: 8 data bits LSB first,
//     odd parity, then release data for the stop bit.
//   - Sample the device ACK on fall 11.
//   - Wait for the bus to return to idle.
//
// Ports:
//   clk_i         system clock
//   res_n_i       asynchronous active-low reset
//   tx_data_i     byte to send
//   tx_valid_i    request; accepted when tx_valid_i & tx_ready_o
//   tx_ready_o    high only while idle
//   busy_o        high while a frame is in progress
//   done_o        1-cycle pulse: frame acknowledged, bus back to idle
//   error_o       1-cycle pulse: missing ACK or timeout
//   ps2_clk_i     pad level of PS/2 clock
//   ps2_clk_oe_o  1 = pull PS/2 clock low
//   ps2_dat_i     pad level of PS/2 data
//   ps2_dat_oe_o  1 = pull PS/2 data low
// ----------------------------------------------------------------------------
module ps2_host_tx #(
  parameter int INHIBIT_CYC = 4000,
  parameter int FILT_CYC    = 8,
  parameter int TIMEOUT_CYC = 600000
) (
  input  logic       clk_i,
  input  logic       res_n_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       error_o,
  input  logic       ps2_clk_i,
  output logic       ps2_clk_oe_o,
  input  logic       ps2_dat_i,
  output logic       ps2_dat_oe_o
);

  localparam int INH_W = (INHIBIT_CYC > 1) ? $clog2(INHIBIT_CYC) : 1;
  localparam int FLT_W = (FILT_CYC > 1) ? $clog2(FILT_CYC) : 1;
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

  localparam logic [INH_W-1:0] INH_LOAD = INH_W'(INHIBIT_CYC - 1);
  localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILT_CYC - 1);
  localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_CYC);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_RTS, S_DATA, S_PARITY, S_STOP, S_ACK, S_WAIT_IDLE
  } state_t;

  logic [1:0]       clk_sync, dat_sync;
  logic             clk_s, dat_s;
  logic             filt_clk, filt_prev;
  logic [FLT_W-1:0] filt_cnt;
  logic             fall;

  state_t           state_q, state_d;
  logic [INH_W-1:0] inh_q, inh_d;
  logic [TO_W-1:0]  to_q;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       byte_q;
  logic             par_q;
  logic             dat_q, dat_d;
  logic             in_frame, timeout_hit, accept;

  // Input conditioning. The idle bus level is high, so the synchronisers and
  // the filter reset to 1 to avoid a spurious fall after reset.
  // NOTE: every register here resets asynchronously so a reset mid-frame
  // releases the open-drain lines immediately, without waiting for a clock.
  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      clk_sync  <= 2'b11;
      dat_sync  <= 2'b11;
      filt_clk  <= 1'b1;
      filt_prev <= 1'b1;
      filt_cnt  <= '0;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk_i};
      dat_sync  <= {dat_sync[0], ps2_dat_i};
      filt_prev <= filt_clk;
      // A new level is adopted only after it has differed from the filtered
      // level for FILT_CYC consecutive cycles; shorter glitches are dropped.
      if (clk_s == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FLT_LAST) begin
        filt_clk <= clk_s;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign clk_s = clk_sync[1];
  assign dat_s = dat_sync[1];

  assign ps2_clk_oe_o = (state_q == S_INHIBIT);
  // Falls produced by our own inhibit are not device clocks.
  assign fall         = filt_prev & ~filt_clk & ~ps2_clk_oe_o;
  assign in_frame     = (state_q != S_IDLE) && (state_q != S_INHIBIT);
  assign timeout_hit  = in_frame && (to_q == TO_LIMIT);
  assign accept       = (state_q == S_IDLE) && tx_valid_i;
  assign tx_ready_o   = (state_q == S_IDLE);
  assign busy_o       = (state_q != S_IDLE);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    state_d      = state_q;
    inh_d        = inh_q;
    idx_d        = idx_q;
    dat_d        = dat_q;
    done_o       = 1'b0;
    error_o      = 1'b0;
    ps2_dat_oe_o = dat_q;

    unique case (state_q)
      S_IDLE: begin
        if (tx_valid_i) begin
          state_d = S_INHIBIT;
          inh_d   = INH_LOAD;
        end
      end
      S_INHIBIT: begin
        // Data goes low on the last inhibit cycle so the start bit is
        // already present when the clock is released.
        ps2_dat_oe_o = (inh_q == '0);
        if (inh_q == '0) begin
          state_d = S_RTS;
          dat_d   = 1'b1;
          idx_d   = 3'd0;
        end else begin
          inh_d = inh_q - 1'b1;
        end
      end
      S_RTS: begin
        if (fall) begin
          dat_d   = ~byte_q[0];
          idx_d   = 3'd1;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (fall) begin
          dat_d = ~byte_q[idx_q];
          if (idx_q == 3'd7) state_d = S_PARITY;
          else               idx_d   = idx_q + 3'd1;
        end
      end
      S_PARITY: begin
        if (fall) begin
          dat_d   = ~par_q;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (fall) begin
          dat_d   = 1'b0;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (fall) begin
          if (dat_s) begin
            error_o = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_WAIT_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (filt_clk && dat_s) begin
          done_o  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A timeout wins over anything else this cycle, including a fall. The
    // lines are released in the same cycle as the error pulse.
    if (timeout_hit) begin
      state_d      = S_IDLE;
      done_o       = 1'b0;
      error_o      = 1'b1;
      ps2_dat_oe_o = 1'b0;
    end
    if (state_d == S_IDLE) dat_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge res_n_i) begin
    if (!res_n_i) begin
      state_q <= S_IDLE;
      inh_q   <= '0;
      idx_q   <= '0;
      dat_q   <= 1'b0;
      to_q    <= '0;
      byte_q  <= '0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      inh_q   <= inh_d;
      idx_q   <= idx_d;
      dat_q   <= dat_d;
      if (accept) begin
        byte_q <= tx_data_i;
        par_q  <= ~^tx_data_i;
      end
      // The timeout counter is zero when the clock is released, then
      // saturates at its limit.
      if (!in_frame)            to_q <= '0;
      else if (to_q != TO_LIMIT) to_q <= to_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// ----------------------------------------------------------------------------
// tb_ps2_host_tx
// Directed plus random bench for ps2_host_tx. A behavioural keyboard model
// clocks the bus, records the level of the data line before every rising
// edge, and optionally drives the ACK. Expected frame contents come from the
// byte itself: start 0, data LSB first, parity chosen so the count of ones
// over data+parity is odd, stop 1.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int INH  = 300;
  localparam int FILT = 8;
  localparam int TO   = 2000;
  localparam int HALF = 40;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, done, error, clk_oe, dat_oe;
  logic       dev_clk = 1'b1, dev_dat = 1'b1, glitch = 1'b0;

  wire clk_pad = !clk_oe && dev_clk && !glitch;
  wire dat_pad = !dat_oe && dev_dat;

  ps2_host_tx #(.INHIBIT_CYC(INH), .FILT_CYC(FILT), .TIMEOUT_CYC(TO)) dut (
    .clk_i        (clk),
    .res_n_i      (rst_n),
    .tx_data_i    (tx_data),
    .tx_valid_i   (tx_valid),
    .tx_ready_o   (tx_ready),
    .busy_o       (busy),
    .done_o       (done),
    .error_o      (error),
    .ps2_clk_i    (clk_pad),
    .ps2_clk_oe_o (clk_oe),
    .ps2_dat_i    (dat_pad),
    .ps2_dat_oe_o (dat_oe)
  );

  always #12.5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Event monitor, sampled on the falling edge.
  int   cyc = 0, done_cnt = 0, err_cnt = 0, both_cnt = 0;
  int   done_cyc = -10, err_cyc = -10, rise_cyc = -10, release_cyc = -10;
  int   run = 0, last_run = 0;
  logic err_clk_oe = 1'b0, err_dat_oe = 1'b0;
  logic ready_after_err = 1'b0, ready_after_done = 1'b0;
  logic prev_oe = 1'b0, prev_dat = 1'b0, prev2_dat = 1'b0;
  logic last_inh_dat = 1'b0, prelast_inh_dat = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (done && error) both_cnt++;
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (error) begin
      err_cnt++; err_cyc = cyc; err_clk_oe = clk_oe; err_dat_oe = dat_oe;
    end
    if (cyc == done_cyc + 1) ready_after_done = tx_ready;
    if (cyc == err_cyc + 1)  ready_after_err  = tx_ready;
    if (clk_oe && !prev_oe) begin rise_cyc = cyc; run = 0; end
    if (clk_oe) run++;
    if (!clk_oe && prev_oe) begin
      last_run = run; release_cyc = cyc;
      last_inh_dat = prev_dat; prelast_inh_dat = prev2_dat;
    end
    prev2_dat = prev_dat;
    prev_dat  = dat_oe;
    prev_oe   = clk_oe;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [7:0] b, input bit keep);
    tx_data  = b;
    tx_valid = 1'b1;
    tick(1);
    if (!keep) tx_valid = 1'b0;
  endtask

  // Wait for the inhibit to begin and then for the clock to be released.
  task automatic wait_release(output bit ok);
    int t;
    t = 0;
    while (!clk_oe && t < 50) begin tick(1); t++; end
    ok = clk_oe;
    t = 0;
    while (clk_oe && t < INH + 50) begin tick(1); t++; end
    if (clk_oe) ok = 1'b0;
  endtask

  // Keyboard model: bits[0] is the start bit, bits[k] the line level
  // sampled just before rising edge k.
  task automatic device_frame(input int n_falls, input bit ack, input bit do_glitch,
                              output logic [10:0] bits, output bit ok);
    bits = '1;
    wait_release(ok);
    tick(20);
    bits[0] = dat_pad;
    for (int k = 1; k <= n_falls; k++) begin
      dev_clk = 1'b0;
      if (k == 11 && ack) dev_dat = 1'b0;
      tick(HALF);
      if (k <= 10) bits[k] = dat_pad;
      dev_clk = 1'b1;
      if (k == 11) dev_dat = 1'b1;
      if (do_glitch && k == 3) begin
        tick(HALF / 2);
        glitch = 1'b1;
        tick(2);
        glitch = 1'b0;
        tick(HALF / 2 - 2);
      end else begin
        tick(HALF);
      end
    end
  endtask

  task automatic wait_end(input int d0, input int e0, output bit got);
    int t;
    t = 0;
    while (done_cnt == d0 && err_cnt == e0 && t < 300) begin tick(1); t++; end
    got = (done_cnt != d0) || (err_cnt != e0);
  endtask

  task automatic check_frame(input string tag, input logic [7:0] b, input logic [10:0] bits);
    logic [7:0] d;
    logic       exp_par;
    for (int i = 0; i < 8; i++) d[i] = bits[i + 1];
    exp_par = ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
    check({tag, "_start"},  32'(bits[0]),  32'd0);
    check({tag, "_data"},   32'(d),        32'(b));
    check({tag, "_parity"}, 32'(bits[9]),  32'(exp_par));
    check({tag, "_stop"},   32'(bits[10]), 32'd1);
  endtask

  task automatic full_frame(input string tag, input logic [7:0] b, input bit do_glitch);
    int          d0, e0;
    logic [10:0] bits;
    bit          ok, got;
    d0 = done_cnt;
    e0 = err_cnt;
    check({tag, "_ready"}, 32'(tx_ready), 32'd1);
    send(b, 1'b0);
    device_frame(11, 1'b1, do_glitch, bits, ok);
    wait_end(d0, e0, got);
    check({tag, "_sync"}, 32'(ok), 32'd1);
    check({tag, "_ended"}, 32'(got), 32'd1);
    check_frame(tag, b, bits);
    check({tag, "_done"}, 32'(done_cnt - d0), 32'd1);
    check({tag, "_noerr"}, 32'(err_cnt - e0), 32'd0);
  endtask

  initial begin
    int          d0, e0, t;
    logic [10:0] bits;
    bit          ok, got;

    // Reset state
    tick(3);
    check("rst_ready",  32'(tx_ready), 32'd1);
    check("rst_busy",   32'(busy),     32'd0);
    check("rst_clk_oe", 32'(clk_oe),   32'd0);
    check("rst_dat_oe", 32'(dat_oe),   32'd0);
    check("rst_done",   32'(done),     32'd0);
    check("rst_error",  32'(error),    32'd0);
    rst_n = 1'b1;
    tick(5);

    // 1: set-LEDs command, inhibit length and start-bit timing
    full_frame("ed", 8'hED, 1'b0);
    check("ed_inhibit_len",   32'(last_run),        32'(INH));
    check("ed_inh_last_dat",  32'(last_inh_dat),    32'd1);
    check("ed_inh_prev_dat",  32'(prelast_inh_dat), 32'd0);
    check("ed_ready_after",   32'(ready_after_done), 32'd1);
    tick(10);

    // 2: back-to-back 0x00 then 0xFF with valid held
    d0 = done_cnt;
    e0 = err_cnt;
    send(8'h00, 1'b1);
    tx_data = 8'hFF;
    device_frame(11, 1'b1, 1'b0, bits, ok);
    wait_end(d0, e0, got);
    check("b2b0_sync", 32'(ok), 32'd1);
    check_frame("b2b0", 8'h00, bits);
    t = 0;
    while (!clk_oe && t < 50) begin tick(1); t++; end
    // Accepted in the cycle after done_o; the inhibit drives from the next.
    check("b2b_ready_after_done", 32'(ready_after_done), 32'd1);
    check("b2b_restart_gap", 32'(rise_cyc - done_cyc), 32'd2);
    tx_valid = 1'b0;
    device_frame(11, 1'b1, 1'b0, bits, ok);
    wait_end(d0 + 1, e0, got);
    check("b2b1_sync", 32'(ok), 32'd1);
    check_frame("b2b1", 8'hFF, bits);
    check("b2b_done", 32'(done_cnt - d0), 32'd2);
    check("b2b_noerr", 32'(err_cnt - e0), 32'd0);
    tick(10);

    // 3: device omits the ACK
    d0 = done_cnt;
    e0 = err_cnt;
    send(8'h3C, 1'b0);
    device_frame(11, 1'b0, 1'b0, bits, ok);
    wait_end(d0, e0, got);
    check("nack_err",    32'(err_cnt - e0),  32'd1);
    check("nack_nodone", 32'(done_cnt - d0), 32'd0);
    check("nack_clk_oe", 32'(err_clk_oe),    32'd0);
    check("nack_dat_oe", 32'(err_dat_oe),    32'd0);
    check("nack_ready",  32'(ready_after_err), 32'd1);
    tick(10);

    // 4: device never clocks after request-to-send
    d0 = done_cnt;
    e0 = err_cnt;
    send(8'hA5, 1'b0);
    wait_release(ok);
    check("to_sync", 32'(ok), 32'd1);
    t = 0;
    while (err_cnt == e0 && t < TO + 100) begin tick(1); t++; end
    check("to_err",     32'(err_cnt - e0),            32'd1);
    check("to_nodone",  32'(done_cnt - d0),           32'd0);
    check("to_latency", 32'(err_cyc - release_cyc),   32'(TO));
    check("to_clk_oe",  32'(err_clk_oe),              32'd0);
    check("to_dat_oe",  32'(err_dat_oe),              32'd0);
    check("to_ready",   32'(ready_after_err),         32'd1);
    tick(10);

    // 5: reset after fall 4 (bit3 of 0x00 keeps data pulled low)
    send(8'h00, 1'b0);
    device_frame(4, 1'b0, 1'b0, bits, ok);
    check("rst4_dat_before", 32'(dat_oe), 32'd1);
    check("rst4_busy_before", 32'(busy),  32'd1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rst4_clk_oe", 32'(clk_oe),   32'd0);
    check("rst4_dat_oe", 32'(dat_oe),   32'd0);
    check("rst4_ready",  32'(tx_ready), 32'd1);
    tick(3);
    rst_n = 1'b1;
    tick(3);
    full_frame("post_rst", 8'h5A, 1'b0);
    tick(10);

    // 6: short glitch on the clock during data bits
    full_frame("glitch", 8'hC3, 1'b1);
    tick(10);

    // Random bytes
    for (int i = 0; i < 3; i++) begin
      full_frame("rand", 8'($urandom), 1'b0);
      tick(5 + int'($urandom_range(0, 20)));
    end

    check("exclusive_pulses", 32'(both_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
